// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, registered carry, LSB-first.
// Operands are captured on an accepted start and shifted through the cell
// over WIDTH cycles. Result bits enter sum at the MSB end.

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic carryin,
  output logic sum,
  output logic carry
);

  // Single-bit combinational add
  always_comb begin
    sum   = in1 ^ in2 ^ carryin;
    carry = (in1 & in2) | (carryin & (in1 ^ in2));
  end

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder fa (
    .in1     (sa[0]),
    .in2     (sb[0]),
    .carryin (c),
    .sum     (fa_sum),
    .carry   (fa_carry)
  );

  // Control FSM with registered busy/done, plus the operand/result datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      c     <= 1'b0;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            c     <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          sum <= {fa_sum, sum[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= fa_carry;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
